// File: rtl/led_pkg.sv
// Shared types and default matrix geometry for the LED display path.
// The default geometry matches the dancing_lights pattern width.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  localparam int unsigned LED_ROWS = 4;
  localparam int unsigned LED_COLS = 8;

  // Counter width for a bound, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Loadable down-counter for blank/dwell timing.
// Exposes a terminal-count strobe and an up-counting phase for the PWM compare.
module led_scan_timer #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [WIDTH-1:0]    i_load_val,
  output logic                o_tc,
  output logic [PWM_BITS-1:0] o_phase
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

  // Loads are (multiple of 2**PWM_BITS) - 1, so the inverted low bits count up from 0.
  assign o_phase = ~r_cnt[PWM_BITS-1:0];

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered LED matrix scanner: accepts frames over valid/ready and
// multiplexes them onto row/column pins with blanking and PWM brightness.
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int unsigned ROWS         = LED_ROWS,
  parameter int unsigned COLS         = LED_COLS,
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_valid,
  input  logic [ROWS*COLS-1:0] frame_data,
  output logic                 frame_ready,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_drv,
  output logic                 frame_done
);

  localparam int unsigned FrameW = ROWS * COLS;
  localparam int unsigned RowW   = cnt_width(ROWS);
  localparam int unsigned CntW   =
      cnt_width((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES);
  localparam logic [RowW-1:0] LastRow   = RowW'(ROWS - 1);
  localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);

  scan_state_t         r_state;
  logic                r_pend_full;
  logic [FrameW-1:0]   r_pend_data;
  logic [FrameW-1:0]   r_shadow;
  logic [RowW-1:0]     r_row;
  logic [PWM_BITS-1:0] r_bright;
  logic                r_ready;
  logic [ROWS-1:0]     r_row_sel;
  logic [COLS-1:0]     r_col_drv;
  logic                r_frame_done;

  scan_state_t         w_state_nxt;
  logic                w_pend_clr;
  logic                w_pend_full_nxt;
  logic                w_accept;
  logic [FrameW-1:0]   w_shadow_nxt;
  logic [RowW-1:0]     w_row_nxt;
  logic [PWM_BITS-1:0] w_bright_nxt;
  logic                w_load;
  logic [CntW-1:0]     w_load_val;
  logic                w_frame_end;
  logic                w_tc;
  logic [PWM_BITS-1:0] w_phase;
  logic [PWM_BITS-1:0] w_phase_nxt;
  logic [ROWS-1:0]     w_onehot;
  logic [COLS-1:0]     w_row_bits;
  logic [ROWS-1:0]     w_row_sel_nxt;
  logic [COLS-1:0]     w_col_drv_nxt;

  led_scan_timer #(
    .WIDTH    (CntW),
    .PWM_BITS (PWM_BITS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc),
    .o_phase    (w_phase)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pend_clr   = 1'b0;
    w_shadow_nxt = r_shadow;
    w_row_nxt    = r_row;
    w_bright_nxt = r_bright;
    w_load       = 1'b0;
    w_load_val   = BlankLoad;
    w_frame_end  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend_full) begin
          w_state_nxt  = BLANK;
          w_load       = 1'b1;
          w_shadow_nxt = r_pend_data;
          w_pend_clr   = 1'b1;
          w_row_nxt    = '0;
        end
      end
      BLANK: begin
        if (w_tc) begin
          w_state_nxt  = DRIVE;
          w_load       = 1'b1;
          w_load_val   = DwellLoad;
          w_bright_nxt = brightness;
        end
      end
      DRIVE: begin
        if (w_tc) begin
          w_state_nxt = BLANK;
          w_load      = 1'b1;
          if (r_row == LastRow) begin
            w_frame_end = 1'b1;
            w_row_nxt   = '0;
            // Swap only at frame end so a frame is never torn.
            if (r_pend_full) begin
              w_shadow_nxt = r_pend_data;
              w_pend_clr   = 1'b1;
            end
          end else begin
            w_row_nxt = r_row + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accept and clear are exclusive: accept needs pending empty, clear needs it full.
  assign w_accept        = frame_valid && r_ready;
  assign w_pend_full_nxt = w_accept ? 1'b1 : (w_pend_clr ? 1'b0 : r_pend_full);

  // Outputs are registered from next-state values so pins line up with the state.
  always_comb begin
    w_onehot   = '0;
    w_row_bits = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r_row == RowW'(r)) begin
        w_onehot[r] = 1'b1;
        w_row_bits  = r_shadow[r*COLS +: COLS];
      end
    end
    w_phase_nxt   = (r_state == DRIVE) ? (w_phase + 1'b1) : '0;
    w_row_sel_nxt = '0;
    w_col_drv_nxt = '0;
    if (w_state_nxt == DRIVE) begin
      w_row_sel_nxt = w_onehot;
      if (w_phase_nxt < w_bright_nxt) begin
        w_col_drv_nxt = w_row_bits;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pend_full  <= 1'b0;
      r_pend_data  <= '0;
      r_shadow     <= '0;
      r_row        <= '0;
      r_bright     <= '0;
      r_ready      <= 1'b0;
      r_row_sel    <= '0;
      r_col_drv    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_full  <= w_pend_full_nxt;
      if (w_accept) begin
        r_pend_data <= frame_data;
      end
      r_shadow     <= w_shadow_nxt;
      r_row        <= w_row_nxt;
      r_bright     <= w_bright_nxt;
      r_ready      <= !w_pend_full_nxt;
      r_row_sel    <= w_row_sel_nxt;
      r_col_drv    <= w_col_drv_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign frame_ready = r_ready;
  assign row_sel     = r_row_sel;
  assign col_drv     = r_col_drv;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: vector table plus multi-cycle sequences.
module tb_led_matrix_scanner;

  localparam int FramePeriod = 72;  // 4 rows x (2 blank + 16 drive)

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [31:0] frame_data = '0;
  logic        frame_ready;
  logic [1:0]  brightness = '0;
  logic [3:0]  row_sel;
  logic [7:0]  col_drv;
  logic        frame_done;

  led_matrix_scanner #(
    .ROWS         (4),
    .COLS         (8),
    .DWELL_CYCLES (16),
    .BLANK_CYCLES (2),
    .PWM_BITS     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .row_sel     (row_sel),
    .col_drv     (col_drv),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] frame;
    logic [1:0]  bright;
    logic [7:0]  row0;
    logic [7:0]  row3;
    int          on3;
  } vec_t;

  vec_t vecs[4];

  int n_total = 0;
  int n_bad = 0;

  // Reference state of the buffers and scan position.
  logic [31:0] m_shadow, m_pend_data;
  logic        m_pend;
  logic [1:0]  m_bright;
  int          pos, g;
  int          on_cnt[4];
  logic [7:0]  seen[4];

  // Stimulus hooks keyed on g (cycles since the first drive cycle).
  int          offer_at, third_until, bchg_at;
  logic [31:0] offer_data, third_data;
  logic [1:0]  bchg_val;
  bit          offering;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name, input logic exp_ready);
    chk(name, 32'({frame_done, row_sel, col_drv, frame_ready}), 32'({13'd0, exp_ready}));
  endtask

  task automatic clear_hooks();
    offer_at    = -1;
    third_until = -1;
    bchg_at     = -1;
    offering    = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    frame_valid = 1'b0;
    clear_hooks();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("in_reset", 1'b0);
    end
    reset = 1'b0;
    tick();
    chk_quiet("ready_after_reset", 1'b1);
  endtask

  // Hands a frame to an idle block and steps to its first drive cycle.
  task automatic send_first(input logic [31:0] data);
    int waited;
    waited      = 0;
    frame_data  = data;
    frame_valid = 1'b1;
    while (!frame_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("send_ready_seen", 32'(frame_ready), 32'd1);
    tick();
    frame_valid = 1'b0;
    chk_quiet("first_idle", 1'b0);
    tick();
    chk_quiet("first_blank0", 1'b1);
    tick();
    chk_quiet("first_blank1", 1'b1);
    tick();
    m_shadow = data;
    m_pend   = 1'b0;
    m_bright = brightness;
    pos      = 0;
    g        = 0;
  endtask

  task automatic run(input int n);
    int         r, k;
    logic [7:0] rb, ecol;
    logic [3:0] ers;
    logic       edone, acc;
    for (int c = 0; c < n; c++) begin
      r     = pos / 18;
      k     = pos % 18;
      rb    = m_shadow[r*8 +: 8];
      ers   = (k < 16) ? (4'b0001 << r) : 4'b0000;
      ecol  = (k < 16 && (k % 4) < int'(m_bright)) ? rb : 8'h00;
      edone = (pos == 70);
      chk($sformatf("scan g%0d pos%0d", g, pos),
          32'({frame_done, row_sel, col_drv, frame_ready}),
          32'({edone, ers, ecol, ~m_pend}));
      if (k < 16) begin
        if (k == 0) begin
          seen[r]   = 8'h00;
          on_cnt[r] = 0;
        end
        seen[r] = seen[r] | col_drv;
        if (col_drv != 8'h00) on_cnt[r]++;
      end
      if (g == bchg_at) brightness = bchg_val;
      if (g == offer_at) begin
        frame_valid = 1'b1;
        frame_data  = offer_data;
        offering    = 1'b1;
      end
      if (g == third_until) frame_valid = 1'b0;
      acc = frame_valid && !m_pend;
      if (pos == 69 && m_pend) begin
        m_shadow = m_pend_data;
        m_pend   = 1'b0;
      end else if (acc) begin
        m_pend      = 1'b1;
        m_pend_data = frame_data;
      end
      if (k == 17) m_bright = brightness;
      tick();
      pos = (pos + 1) % FramePeriod;
      if (acc && offering) begin
        offering = 1'b0;
        if (third_until > g) frame_data = third_data;
        else frame_valid = 1'b0;
      end
      g++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hA5C3_0F81, 2'd3, 8'h81, 8'hA5, 12};
    vecs[1] = '{32'hFFFF_0000, 2'd1, 8'h00, 8'hFF, 4};
    vecs[2] = '{32'h1234_5678, 2'd2, 8'h78, 8'h12, 8};
    vecs[3] = '{32'hDEAD_BEEF, 2'd0, 8'h00, 8'h00, 0};
    clear_hooks();

    // Reset then idle with no valid.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_quiet("idle", 1'b1);
    end

    // Table: one frame per vector, shown twice to check repeat and frame_done period.
    for (int v = 0; v < 4; v++) begin
      brightness = vecs[v].bright;
      do_reset();
      send_first(vecs[v].frame);
      run(FramePeriod);
      chk($sformatf("vec%0d_row0", v), 32'(seen[0]), 32'(vecs[v].row0));
      chk($sformatf("vec%0d_row3", v), 32'(seen[3]), 32'(vecs[v].row3));
      chk($sformatf("vec%0d_on3", v), 32'(on_cnt[3]), 32'(vecs[v].on3));
      run(FramePeriod);
    end

    // Brightness 1 -> 2 in the middle of row1 only affects row2 onward.
    brightness = 2'd1;
    do_reset();
    send_first(32'hFFFF_FFFF);
    bchg_at  = 26;
    bchg_val = 2'd2;
    run(FramePeriod);
    chk("bchg_row0_on", 32'(on_cnt[0]), 32'd4);
    chk("bchg_row1_on", 32'(on_cnt[1]), 32'd4);
    chk("bchg_row2_on", 32'(on_cnt[2]), 32'd8);
    chk("bchg_row3_on", 32'(on_cnt[3]), 32'd8);

    // Mid-frame offer, third frame held valid while pending is full.
    brightness = 2'd3;
    do_reset();
    send_first(32'hA5C3_0F81);
    offer_at    = 20;
    offer_data  = 32'h1234_5678;
    third_until = 70;
    third_data  = 32'h5A5A_5A5A;
    run(FramePeriod);
    chk("midoffer_old_row0", 32'(seen[0]), 32'h81);
    run(FramePeriod);
    chk("midoffer_new_row0", 32'(seen[0]), 32'h78);
    run(FramePeriod);
    chk("midoffer_third_dropped", 32'(seen[3]), 32'h12);

    // Offer exactly on the frame-end edge: old frame repeats once first.
    brightness = 2'd2;
    do_reset();
    send_first(32'hA5C3_0F81);
    offer_at   = 69;
    offer_data = 32'h1234_5678;
    run(FramePeriod);
    chk("edge_frame1_row0", 32'(seen[0]), 32'h81);
    run(FramePeriod);
    chk("edge_repeat_row0", 32'(seen[0]), 32'h81);
    run(FramePeriod);
    chk("edge_new_row0", 32'(seen[0]), 32'h78);

    // Reset during row2 with a frame pending: everything is dropped.
    brightness = 2'd3;
    do_reset();
    send_first(32'hA5C3_0F81);
    offer_at   = 5;
    offer_data = 32'h1234_5678;
    run(41);
    chk("pre_reset_row2", 32'(row_sel), 32'h4);
    clear_hooks();
    reset = 1'b1;
    tick();
    chk_quiet("midreset_next", 1'b0);
    reset = 1'b0;
    tick();
    chk_quiet("midreset_release", 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_quiet("post_reset_idle", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
